trap_controller: RTL and testbench

- Sequences machine-mode trap entry and MRET return around the CSR file.
- Takes synchronous exceptions from the pipeline, MRET requests and three interrupt lines, and picks one winner.
- Produces the exception write bundle for the CSR file: we_exc, mcause_d, mepc_d, mstatus_d, mtval_d.
- Issues a pipeline flush/redirect to the trap vector or to mepc; sits between the execute/writeback stage, the CSR file and the fetch unit.

---
 rtl/csr_pkg.sv | 39 +++
 rtl/trap_controller_if.sv | 50 +++++
 rtl/trap_irq_prio.sv | 37 +++
 rtl/trap_controller.sv | 178 +++++++++++++++++
 tb/tb_trap_controller.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions for the machine-mode trap path: CSR addresses,
// cause codes, mstatus field positions and the trap sequencer state type.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    localparam logic [3:0] INT_MSI = 4'd3;
    localparam logic [3:0] INT_MTI = 4'd7;
    localparam logic [3:0] INT_MEI = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP_WR  = 2'd1,
        MRET_WR  = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

endpackage

// File: rtl/trap_controller_if.sv
// Bundle between the pipeline/CSR file (master side) and the trap controller
// (slave side). Event inputs are levels sampled by the controller while idle.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    import csr_pkg::*;

    logic            exc_valid_i;
    logic [3:0]      exc_code_i;
    logic [XLEN-1:0] exc_pc_i;
    logic [XLEN-1:0] exc_tval_i;
    logic            mret_i;
    logic            irq_msip_i;
    logic            irq_mtip_i;
    logic            irq_meip_i;
    logic [XLEN-1:0] next_pc_i;
    logic [XLEN-1:0] mstatus_i;
    logic [XLEN-1:0] mie_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic [XLEN-1:0] mcause_i;
    logic [XLEN-1:0] mtval_i;

    logic            we_exc_o;
    logic [XLEN-1:0] mcause_d_o;
    logic [XLEN-1:0] mepc_d_o;
    logic [XLEN-1:0] mstatus_d_o;
    logic [XLEN-1:0] mtval_d_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            busy_o;
    trap_state_t     state_dbg_o;

    modport master (
        output exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_i,
        output irq_msip_i, irq_mtip_i, irq_meip_i, next_pc_i,
        output mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i, mtval_i,
        input  we_exc_o, mcause_d_o, mepc_d_o, mstatus_d_o, mtval_d_o,
        input  redirect_o, redirect_pc_o, busy_o, state_dbg_o
    );

    modport slave (
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_i,
        input  irq_msip_i, irq_mtip_i, irq_meip_i, next_pc_i,
        input  mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i, mtval_i,
        output we_exc_o, mcause_d_o, mepc_d_o, mstatus_d_o, mtval_d_o,
        output redirect_o, redirect_pc_o, busy_o, state_dbg_o
    );

endinterface

// File: rtl/trap_irq_prio.sv
// Interrupt mask-and-priority encoder: qualifies the three machine interrupt
// lines by global MIE and their enable bits, then picks MEI > MSI > MTI.
module trap_irq_prio
    import csr_pkg::*;
(
    input  logic       i_global_ie,
    input  logic       i_msie,
    input  logic       i_mtie,
    input  logic       i_meie,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic       i_meip,
    output logic       o_irq_valid,
    output logic [3:0] o_irq_code
);

    logic w_msi;
    logic w_mti;
    logic w_mei;

    assign w_msi = i_global_ie & i_msie & i_msip;
    assign w_mti = i_global_ie & i_mtie & i_mtip;
    assign w_mei = i_global_ie & i_meie & i_meip;

    always_comb begin
        o_irq_valid = w_mei | w_msi | w_mti;
        o_irq_code  = 4'd0;
        if (w_mei) begin
            o_irq_code = INT_MEI;
        end else if (w_msi) begin
            o_irq_code = INT_MSI;
        end else if (w_mti) begin
            o_irq_code = INT_MTI;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer feeding the CSR exception write port
// and the fetch redirect. Define TRAP_VECTORED_MTVEC_EN for vectored interrupts.
module trap_controller
    import csr_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter logic [1:0] MPP_VALUE = 2'b11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    trap_controller_if.slave bus
);

    trap_state_t     r_state;
    trap_state_t     w_state_nxt;

    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_irq_valid;
    logic [3:0]      w_irq_code;
    logic            w_idle;
    logic            w_take_exc;
    logic            w_take_mret;
    logic            w_take_irq;
    logic            w_take_trap;

    logic [XLEN-1:0] w_trap_mcause;
    logic [XLEN-1:0] w_trap_mepc;
    logic [XLEN-1:0] w_trap_mtval;
    logic [XLEN-1:0] w_trap_mstatus;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_mtvec_base;
    logic [XLEN-1:0] w_mret_mstatus;
    logic [XLEN-1:0] w_mret_pc;

    trap_irq_prio u_irq_prio (
        .i_global_ie (bus.mstatus_i[MSTATUS_MIE]),
        .i_msie      (bus.mie_i[3]),
        .i_mtie      (bus.mie_i[7]),
        .i_meie      (bus.mie_i[11]),
        .i_msip      (bus.irq_msip_i),
        .i_mtip      (bus.irq_mtip_i),
        .i_meip      (bus.irq_meip_i),
        .o_irq_valid (w_irq_valid),
        .o_irq_code  (w_irq_code)
    );

    // Single winner per idle cycle: exception, then MRET, then interrupt.
    assign w_idle      = (r_state == IDLE);
    assign w_take_exc  = w_idle & bus.exc_valid_i;
    assign w_take_mret = w_idle & ~bus.exc_valid_i & bus.mret_i;
    assign w_take_irq  = w_idle & ~bus.exc_valid_i & ~bus.mret_i & w_irq_valid;
    assign w_take_trap = w_take_exc | w_take_irq;

    always_comb begin
        w_trap_mcause = '0;
        if (bus.exc_valid_i) begin
            w_trap_mcause[3:0] = bus.exc_code_i;
        end else begin
            w_trap_mcause[XLEN-1] = 1'b1;
            w_trap_mcause[3:0]    = w_irq_code;
        end

        w_trap_mepc      = bus.exc_valid_i ? bus.exc_pc_i : bus.next_pc_i;
        w_trap_mepc[1:0] = 2'b00;
        w_trap_mtval     = bus.exc_valid_i ? bus.exc_tval_i : '0;

        w_trap_mstatus                                = bus.mstatus_i;
        w_trap_mstatus[MSTATUS_MPIE]                  = bus.mstatus_i[MSTATUS_MIE];
        w_trap_mstatus[MSTATUS_MIE]                   = 1'b0;
        w_trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_VALUE;
    end

    always_comb begin
        w_mret_mstatus                                = bus.mstatus_i;
        w_mret_mstatus[MSTATUS_MIE]                   = bus.mstatus_i[MSTATUS_MPIE];
        w_mret_mstatus[MSTATUS_MPIE]                  = 1'b1;
        w_mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_VALUE;

        w_mret_pc      = bus.mepc_i;
        w_mret_pc[1:0] = 2'b00;
    end

    assign w_mtvec_base = {bus.mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_MTVEC_EN
    // Vectored mode only offsets interrupts; exceptions land on the base.
    assign w_trap_pc = (!bus.exc_valid_i && (bus.mtvec_i[1:0] == 2'b01))
                     ? w_mtvec_base + (XLEN'(w_irq_code) << 2)
                     : w_mtvec_base;
`else
    assign w_trap_pc = w_mtvec_base;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_trap) begin
                    w_state_nxt = TRAP_WR;
                end else if (w_take_mret) begin
                    w_state_nxt = MRET_WR;
                end
            end
            TRAP_WR:  w_state_nxt = REDIRECT;
            MRET_WR:  w_state_nxt = REDIRECT;
            REDIRECT: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Bundle is captured at acceptance so later CSR/pipeline changes cannot leak in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcause      <= '0;
            r_mepc        <= '0;
            r_mstatus     <= '0;
            r_mtval       <= '0;
            r_redirect_pc <= '0;
        end else if (w_take_trap) begin
            r_mcause      <= w_trap_mcause;
            r_mepc        <= w_trap_mepc;
            r_mstatus     <= w_trap_mstatus;
            r_mtval       <= w_trap_mtval;
            r_redirect_pc <= w_trap_pc;
        end else if (w_take_mret) begin
            r_mcause      <= bus.mcause_i;
            r_mepc        <= bus.mepc_i;
            r_mstatus     <= w_mret_mstatus;
            r_mtval       <= bus.mtval_i;
            r_redirect_pc <= w_mret_pc;
        end
    end

    // Outputs are suppressed while rst_i is high so a reset mid-sequence never
    // lets a partial write or redirect escape.
    always_comb begin
        bus.we_exc_o      = 1'b0;
        bus.mcause_d_o    = '0;
        bus.mepc_d_o      = '0;
        bus.mstatus_d_o   = '0;
        bus.mtval_d_o     = '0;
        bus.redirect_o    = 1'b0;
        bus.redirect_pc_o = '0;
        bus.busy_o        = (r_state != IDLE);
        bus.state_dbg_o   = r_state;
        if (!rst_i) begin
            case (r_state)
                TRAP_WR, MRET_WR: begin
                    bus.we_exc_o    = 1'b1;
                    bus.mcause_d_o  = r_mcause;
                    bus.mepc_d_o    = r_mepc;
                    bus.mstatus_d_o = r_mstatus;
                    bus.mtval_d_o   = r_mtval;
                end
                REDIRECT: begin
                    bus.redirect_o    = 1'b1;
                    bus.redirect_pc_o = r_redirect_pc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed trap/MRET/interrupt cases plus random
// exceptions and MRETs, checked through a scoreboard of expected CSR writes.
module tb_trap_controller;
    import csr_pkg::*;

    localparam int XLEN = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    bit   mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    trap_controller_if #(.XLEN(XLEN)) bus();

    trap_controller #(.XLEN(XLEN), .MPP_VALUE(2'b11)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // {mcause, mepc, mstatus, mtval}
    logic [127:0] exp_wr_q[$];
    logic [31:0]  exp_rd_q[$];
    logic [127:0] mon_wr;
    logic [31:0]  mon_rd;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [31:0] trap_ms(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[7] = m[3];
        r[3] = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_ms(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[3] = m[7];
        r[7] = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (bus.we_exc_o === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    check("spurious_we", bus.we_exc_o, 1'b0);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("mcause_d", bus.mcause_d_o, mon_wr[127:96]);
                    check("mepc_d", bus.mepc_d_o, mon_wr[95:64]);
                    check("mstatus_d", bus.mstatus_d_o, mon_wr[63:32]);
                    check("mtval_d", bus.mtval_d_o, mon_wr[31:0]);
                end
            end
            if (bus.redirect_o === 1'b1) begin
                if (exp_rd_q.size() == 0) begin
                    check("spurious_redirect", bus.redirect_o, 1'b0);
                end else begin
                    mon_rd = exp_rd_q.pop_front();
                    check("redirect_pc", bus.redirect_pc_o, mon_rd);
                end
            end else begin
                check("redirect_pc_idle", bus.redirect_pc_o, 32'h0);
            end
        end
    end

    task automatic clear_events();
        bus.exc_valid_i = 1'b0;
        bus.mret_i      = 1'b0;
        bus.irq_msip_i  = 1'b0;
        bus.irq_mtip_i  = 1'b0;
        bus.irq_meip_i  = 1'b0;
    endtask

    task automatic set_csrs(input logic [31:0] ms, mie, mtvec, mepc, mcause, mtval);
        bus.mstatus_i = ms;
        bus.mie_i     = mie;
        bus.mtvec_i   = mtvec;
        bus.mepc_i    = mepc;
        bus.mcause_i  = mcause;
        bus.mtval_i   = mtval;
    endtask

    task automatic drive_exc(input logic [3:0] code, input logic [31:0] pc, tval, input logic with_mret);
        @(posedge clk_i); #1;
        bus.exc_valid_i = 1'b1;
        bus.exc_code_i  = code;
        bus.exc_pc_i    = pc;
        bus.exc_tval_i  = tval;
        bus.mret_i      = with_mret;
    endtask

    task automatic drive_mret();
        @(posedge clk_i); #1;
        bus.mret_i = 1'b1;
    endtask

    task automatic drive_irq(input logic msip, mtip, meip, input logic [31:0] npc);
        @(posedge clk_i); #1;
        bus.irq_msip_i = msip;
        bus.irq_mtip_i = mtip;
        bus.irq_meip_i = meip;
        bus.next_pc_i  = npc;
    endtask

    task automatic expect_op(input logic [127:0] wr, input logic [31:0] rd);
        exp_wr_q.push_back(wr);
        exp_rd_q.push_back(rd);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_i);
        while (bus.busy_o !== 1'b0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_idle"}, bus.busy_o, 1'b0);
    endtask

    // Event was driven last cycle; the next edge accepts it.
    task automatic step_accept(input string tag);
        @(posedge clk_i); #1;
        clear_events();
        @(negedge clk_i);
        check({tag, "_we_lat"}, bus.we_exc_o, 1'b1);
        check({tag, "_busy"}, bus.busy_o, 1'b1);
        @(negedge clk_i);
        check({tag, "_redir_lat"}, bus.redirect_o, 1'b1);
        wait_idle(tag);
    endtask

    task automatic step_ignore(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check({tag, "_busy"}, bus.busy_o, 1'b0);
            check({tag, "_we"}, bus.we_exc_o, 1'b0);
        end
        @(posedge clk_i); #1;
        clear_events();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_events();
        set_csrs(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.exc_code_i = 4'd0;
        bus.exc_pc_i   = 32'h0;
        bus.exc_tval_i = 32'h0;
        bus.next_pc_i  = 32'h0;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        mon_en = 1'b1;
        check("rst_we", bus.we_exc_o, 1'b0);
        check("rst_redirect", bus.redirect_o, 1'b0);
        check("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
        check("rst_mcause", bus.mcause_d_o, 32'h0);
        check("rst_mepc", bus.mepc_d_o, 32'h0);
        check("rst_mstatus", bus.mstatus_d_o, 32'h0);
        check("rst_mtval", bus.mtval_d_o, 32'h0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_state", bus.state_dbg_o, IDLE);

        // Exception entry
        set_csrs(32'h8, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0);
        drive_exc(4'd2, 32'h100, 32'hDEAD, 1'b0);
        expect_op({32'h2, 32'h100, 32'h1880, 32'hDEAD}, 32'h200);
        step_accept("exc");

        // MRET return, then one with unaligned mepc
        set_csrs(32'h1880, 32'h0, 32'h200, 32'h104, 32'h2, 32'hDEAD);
        drive_mret();
        expect_op({32'h2, 32'h104, 32'h1888, 32'hDEAD}, 32'h104);
        step_accept("mret");
        set_csrs(32'h0, 32'h0, 32'h200, 32'h10A, 32'h5, 32'h77);
        drive_mret();
        expect_op({32'h5, 32'h10A, 32'h1880, 32'h77}, 32'h108);
        step_accept("mret_unal");

        // Interrupt priority
        set_csrs(32'h8, 32'h888, 32'h200, 32'h0, 32'h0, 32'h0);
        drive_irq(1'b1, 1'b1, 1'b1, 32'h300);
        expect_op({32'h8000000B, 32'h300, 32'h1880, 32'h0}, 32'h200);
        step_accept("irq_mei");
        drive_irq(1'b1, 1'b1, 1'b0, 32'h302);
        expect_op({32'h80000003, 32'h300, 32'h1880, 32'h0}, 32'h200);
        step_accept("irq_msi");
        set_csrs(32'h8, 32'h088, 32'h200, 32'h0, 32'h0, 32'h0);
        drive_irq(1'b1, 1'b1, 1'b1, 32'h404);
        expect_op({32'h80000003, 32'h404, 32'h1880, 32'h0}, 32'h200);
        step_accept("irq_mei_off");

        // Masking: global MIE clear, then enables clear
        set_csrs(32'h0, 32'h888, 32'h200, 32'h0, 32'h0, 32'h0);
        drive_irq(1'b1, 1'b1, 1'b1, 32'h300);
        step_ignore("mie0", 3);
        set_csrs(32'h8, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0);
        drive_irq(1'b1, 1'b1, 1'b1, 32'h300);
        step_ignore("mie_en0", 2);

        // Exception and MRET together, exception taken with MIE=0
        set_csrs(32'h1880, 32'h0, 32'h200, 32'h104, 32'h9, 32'h9);
        drive_exc(4'd5, 32'h400, 32'h44, 1'b1);
        expect_op({32'h5, 32'h400, 32'h1800, 32'h44}, 32'h200);
        step_accept("exc_mret");

        // Events held while busy are ignored
        set_csrs(32'h8, 32'h888, 32'h200, 32'h104, 32'h0, 32'h0);
        drive_exc(4'd4, 32'h600, 32'h66, 1'b0);
        expect_op({32'h4, 32'h600, 32'h1880, 32'h66}, 32'h200);
        @(posedge clk_i); #1;
        bus.exc_code_i = 4'd7;
        bus.mret_i     = 1'b1;
        bus.irq_msip_i = 1'b1;
        bus.irq_mtip_i = 1'b1;
        bus.irq_meip_i = 1'b1;
        @(negedge clk_i);
        check("busy_hold_we", bus.we_exc_o, 1'b1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("busy_hold_redir", bus.redirect_o, 1'b1);
        @(posedge clk_i); #1;
        clear_events();
        @(negedge clk_i);
        check("busy_hold_idle0", bus.busy_o, 1'b0);
        @(negedge clk_i);
        check("busy_hold_idle1", bus.busy_o, 1'b0);

        // Reset in TRAP_WR
        set_csrs(32'h8, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0);
        drive_exc(4'd1, 32'h700, 32'h77, 1'b0);
        @(posedge clk_i); #1;
        clear_events();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_we", bus.we_exc_o, 1'b0);
        check("rstmid_redir", bus.redirect_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rstmid_state", bus.state_dbg_o, IDLE);
        check("rstmid_busy", bus.busy_o, 1'b0);
        @(negedge clk_i);
        check("rstmid_redir2", bus.redirect_o, 1'b0);
        check("rstmid_we2", bus.we_exc_o, 1'b0);

        // Vectored mtvec
        set_csrs(32'h8, 32'h80, 32'h201, 32'h0, 32'h0, 32'h0);
        drive_irq(1'b0, 1'b1, 1'b0, 32'h500);
`ifdef TRAP_VECTORED_MTVEC_EN
        expect_op({32'h80000007, 32'h500, 32'h1880, 32'h0}, 32'h21C);
`else
        expect_op({32'h80000007, 32'h500, 32'h1880, 32'h0}, 32'h200);
`endif
        step_accept("vec_mti");
        drive_exc(4'd3, 32'h504, 32'h0, 1'b0);
        expect_op({32'h3, 32'h504, 32'h1880, 32'h0}, 32'h200);
        step_accept("vec_exc");
        set_csrs(32'h8, 32'h800, 32'hFFFFFFF1, 32'h0, 32'h0, 32'h0);
        drive_irq(1'b0, 1'b0, 1'b1, 32'h600);
`ifdef TRAP_VECTORED_MTVEC_EN
        expect_op({32'h8000000B, 32'h600, 32'h1880, 32'h0}, 32'h1C);
`else
        expect_op({32'h8000000B, 32'h600, 32'h1880, 32'h0}, 32'hFFFFFFF0);
`endif
        step_accept("vec_wrap");

        // Random exceptions and MRETs
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ms, tv, a, b, c;
            logic [3:0]  cd;
            ms = $urandom;
            tv = $urandom;
            a  = $urandom;
            b  = $urandom;
            c  = $urandom;
            cd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                set_csrs(ms, 32'h0, tv, 32'h0, 32'h0, 32'h0);
                drive_exc(cd, a, b, 1'b0);
                expect_op({28'h0, cd, a & ~32'h3, trap_ms(ms), b}, {tv[31:2], 2'b00});
            end else begin
                set_csrs(ms, 32'h0, tv, a, b, c);
                drive_mret();
                expect_op({b, a, mret_ms(ms), c}, a & ~32'h3);
            end
            step_accept("rnd");
        end

        repeat (2) @(negedge clk_i);
        check("wr_q_drained", exp_wr_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
